// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// Multicycle MIPS-subset control unit: Moore FSM whose strobes decode only the registered state.
// Each state lasts one cycle; FETCH-to-FETCH is 2 to 5 cycles depending on the opcode; there is no backpressure.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [3:0] {
    S_FETCH        = 4'd0,
    S_DECODE       = 4'd1,
    S_MEMADDR      = 4'd2,
    S_MEMREAD      = 4'd3,
    S_MEMWB        = 4'd4,
    S_MEMWRITE     = 4'd5,
    S_EXEC         = 4'd6,
    S_RCOMPLETE    = 4'd7,
    S_BRANCH       = 4'd8,
    S_JUMP         = 4'd9,
    S_ADDIEXEC     = 4'd10,
    S_ADDICOMPLETE = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      opcode_q      <= 6'h00;
      illegal_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      illegal_q     <= illegal_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH;
    opcode_d      = opcode_q;
    illegal_d     = 1'b0;
    fetch_count_d = fetch_count_q;
    case (state_q)
      S_FETCH: begin
        state_d       = S_DECODE;
        fetch_count_d = fetch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      S_DECODE: begin
        opcode_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // The live opcode may already belong to the next fetch; use the copy taken in DECODE.
      S_MEMADDR:  state_d = (opcode_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXEC:     state_d = S_RCOMPLETE;
      S_ADDIEXEC: state_d = S_ADDICOMPLETE;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADDR, S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RCOMPLETE: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDICOMPLETE: RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
// Bench for multicycle_control: per-cycle expected state/strobe/counter entries queued per instruction.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  op;
    logic        ill;
    logic [31:0] fc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'h00;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] fetch_count;

  logic        d4_PCWrite, d4_PCWriteCond, d4_IorD, d4_MemRead, d4_MemWrite, d4_MemtoReg;
  logic        d4_IRWrite, d4_ALUSrcA, d4_RegWrite, d4_RegDst;
  logic [1:0]  d4_PCSource, d4_ALUOp, d4_ALUSrcB;
  logic [3:0]  d4_state;
  logic        d4_illegal;
  logic [3:0]  d4_fetch_count;

  logic [77:0] obs;
  exp_t        sb[$];
  logic [31:0] exp_fc = 32'd0;
  logic        pend_ill = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clock = ~clock;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .state(state), .illegal(illegal), .fetch_count(fetch_count)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .opcode(opcode),
    .PCWrite(d4_PCWrite), .PCWriteCond(d4_PCWriteCond), .IorD(d4_IorD), .MemRead(d4_MemRead),
    .MemWrite(d4_MemWrite), .MemtoReg(d4_MemtoReg), .IRWrite(d4_IRWrite), .ALUSrcA(d4_ALUSrcA),
    .RegWrite(d4_RegWrite), .RegDst(d4_RegDst), .PCSource(d4_PCSource), .ALUOp(d4_ALUOp),
    .ALUSrcB(d4_ALUSrcB), .state(d4_state), .illegal(d4_illegal), .fetch_count(d4_fetch_count)
  );

  assign obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, illegal, fetch_count,
                d4_state, d4_PCWrite, d4_PCWriteCond, d4_IorD, d4_MemRead, d4_MemWrite,
                d4_MemtoReg, d4_IRWrite, d4_ALUSrcA, d4_RegWrite, d4_RegDst, d4_PCSource,
                d4_ALUOp, d4_ALUSrcB, d4_illegal, d4_fetch_count};

  // Strobe table per state, ordered as in obs.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, aop, asb;
    pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; m2r = 0; irw = 0; asa = 0; rw = 0; rd = 0;
    pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (s)
      4'd0:  begin mr = 1; irw = 1; pcw = 1; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, pcs, aop, asb};
  endfunction

  // Queue one instruction's cycles; the opcode is presented during FETCH/DECODE, then replaced by scramble.
  task automatic push_instr(input logic [5:0] op, input logic [5:0] scramble);
    logic [3:0] seq[$];
    exp_t e;
    case (op)
      6'h23:   seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'h2B:   seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'h00:   seq = '{4'd0, 4'd1, 4'd6, 4'd7};
      6'h04:   seq = '{4'd0, 4'd1, 4'd8};
      6'h02:   seq = '{4'd0, 4'd1, 4'd9};
      6'h08:   seq = '{4'd0, 4'd1, 4'd10, 4'd11};
      default: seq = '{4'd0, 4'd1};
    endcase
    foreach (seq[i]) begin
      e.st  = seq[i];
      e.op  = (i < 2) ? op : scramble;
      e.ill = pend_ill;
      e.fc  = exp_fc;
      pend_ill = 1'b0;
      sb.push_back(e);
      if (seq[i] == 4'd0) exp_fc = exp_fc + 32'd1;
    end
    pend_ill = !(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08});
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if (obs !== {4'd0, exp_ctrl(4'd0), 1'b0, 32'd0, 4'd0, exp_ctrl(4'd0), 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_hold: got %h required %h", obs,
               {4'd0, exp_ctrl(4'd0), 1'b0, 32'd0, 4'd0, exp_ctrl(4'd0), 1'b0, 4'd0});
    end
    opcode = 6'h23;
    @(negedge clock);
    n_checks++;
    if (obs !== {4'd0, exp_ctrl(4'd0), 1'b0, 32'd0, 4'd0, exp_ctrl(4'd0), 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_after_edge: got %h required %h", obs,
               {4'd0, exp_ctrl(4'd0), 1'b0, 32'd0, 4'd0, exp_ctrl(4'd0), 1'b0, 4'd0});
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    exp_t e;
    push_instr(6'h23, 6'h2B);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      opcode = e.op;
      n_checks++;
      if (obs !== {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]}) begin
        n_fail++;
        $display("FAIL lw state %0d: got %h required %h", e.st, obs,
                 {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]});
      end
      @(negedge clock);
    end
  endtask

  task automatic test_sw();
    exp_t e;
    push_instr(6'h2B, 6'h23);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      opcode = e.op;
      n_checks++;
      if (obs !== {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]}) begin
        n_fail++;
        $display("FAIL sw state %0d: got %h required %h", e.st, obs,
                 {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]});
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    push_instr(6'h00, 6'h3F);
    push_instr(6'h04, 6'h3F);
    push_instr(6'h02, 6'h3F);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      opcode = e.op;
      n_checks++;
      if (obs !== {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]}) begin
        n_fail++;
        $display("FAIL back_to_back state %0d: got %h required %h", e.st, obs,
                 {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]});
      end
      @(negedge clock);
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    push_instr(6'h3F, 6'h00);
    push_instr(6'h08, 6'h23);
    push_instr(6'h11, 6'h00);
    push_instr(6'h08, 6'h00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      opcode = e.op;
      n_checks++;
      if (obs !== {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]}) begin
        n_fail++;
        $display("FAIL illegal state %0d: got %h required %h", e.st, obs,
                 {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]});
      end
      @(negedge clock);
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    push_instr(6'h23, 6'h2B);
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      opcode = e.op;
      n_checks++;
      if (obs !== {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]}) begin
        n_fail++;
        $display("FAIL async_pre state %0d: got %h required %h", e.st, obs,
                 {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]});
      end
      if (i < 3) @(negedge clock);
    end
    sb.delete();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== {4'd0, exp_ctrl(4'd0), 1'b0, 32'd0, 4'd0, exp_ctrl(4'd0), 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset_midcycle: got %h required %h", obs,
               {4'd0, exp_ctrl(4'd0), 1'b0, 32'd0, 4'd0, exp_ctrl(4'd0), 1'b0, 4'd0});
    end
    @(negedge clock);
    reset = 1'b0;
    exp_fc = 32'd0;
    pend_ill = 1'b0;
    push_instr(6'h08, 6'h2B);
    push_instr(6'h23, 6'h00);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      opcode = e.op;
      n_checks++;
      if (obs !== {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]}) begin
        n_fail++;
        $display("FAIL async_resume state %0d: got %h required %h", e.st, obs,
                 {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]});
      end
      @(negedge clock);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_fc = 32'd0;
    pend_ill = 1'b0;
    repeat (17) push_instr(6'h02, 6'h3F);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      opcode = e.op;
      n_checks++;
      if (obs !== {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]}) begin
        n_fail++;
        $display("FAIL wrap state %0d fc %0d: got %h required %h", e.st, e.fc, obs,
                 {e.st, exp_ctrl(e.st), e.ill, e.fc, e.st, exp_ctrl(e.st), e.ill, e.fc[3:0]});
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
